// File: rtl/lwe_op_controller.sv
// lwe_op_controller: command sequencer for the LWE accelerator datapath.
// It takes one command at a time (encrypt, decrypt, homomorphic add) and fetches
// its operands from the shared SRAM. For encrypt it also streams the public-key
// rows. It then starts the selected unit, waits for it with a timeout and writes
// the result back.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   cmd_valid/cmd_ready   command handshake; cmd_op 00 ENC, 01 DEC, 10 ADD, 11 reserved
//   cmd_src_a/b, cmd_dst  operand and result SRAM addresses
//   sram_en/we/addr       SRAM access; read data is valid one cycle after the address
//   load_a, load_b        selected unit captures SRAM read data as operand A / B-or-key
//   row_valid, row        encrypt unit accumulates public-key row 'row'
//   unit_go               one-hot start pulse {add, dec, enc}
//   unit_done             selected unit has its result ready
//   busy, done, status    activity flag, completion pulse, 00 OK / 01 bad op / 10 timeout
module lwe_op_controller #(
    parameter int unsigned BIG_N      = 30,
    parameter int unsigned ROW_WIDTH  = 5,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned PK_BASE    = 0,
    parameter int unsigned SK_BASE    = 32,
    parameter int unsigned TIMEOUT    = 256
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [ADDR_WIDTH-1:0] cmd_src_a,
    input  logic [ADDR_WIDTH-1:0] cmd_src_b,
    input  logic [ADDR_WIDTH-1:0] cmd_dst,
    output logic                  sram_en,
    output logic                  sram_we,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic                  load_a,
    output logic                  load_b,
    output logic                  row_valid,
    output logic [ROW_WIDTH-1:0]  row,
    output logic [2:0]            unit_go,
    input  logic                  unit_done,
    output logic                  busy,
    output logic                  done,
    output logic [1:0]            status
);

    localparam int unsigned WAIT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    localparam logic [1:0] OP_ENC = 2'b00;
    localparam logic [1:0] OP_DEC = 2'b01;
    localparam logic [1:0] OP_ADD = 2'b10;
    localparam logic [1:0] OP_BAD = 2'b11;

    localparam logic [1:0] ST_OK  = 2'b00;
    localparam logic [1:0] ST_BAD = 2'b01;
    localparam logic [1:0] ST_TMO = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH_A,
        S_FETCH_B,
        S_STREAM,
        S_DRAIN,
        S_WAIT,
        S_WRITE,
        S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [1:0]            op_q, op_d;
    logic [ADDR_WIDTH-1:0] src_b_q, src_b_d;
    logic [ADDR_WIDTH-1:0] dst_q, dst_d;
    logic [ROW_WIDTH-1:0]  r_q, r_d;
    logic [WAIT_W-1:0]     wcnt_q, wcnt_d;

    logic                  cmd_ready_q, cmd_ready_d;
    logic                  sram_en_q, sram_en_d;
    logic                  sram_we_q, sram_we_d;
    logic [ADDR_WIDTH-1:0] sram_addr_q, sram_addr_d;
    logic                  load_a_q, load_a_d;
    logic                  load_b_q, load_b_d;
    logic                  row_valid_q, row_valid_d;
    logic [ROW_WIDTH-1:0]  row_q, row_d;
    logic [2:0]            unit_go_q, unit_go_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [1:0]            status_q, status_d;

    // Next state plus the outputs of the state being entered, so every output is a flop.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        src_b_d     = src_b_q;
        dst_d       = dst_q;
        r_d         = r_q;
        wcnt_d      = wcnt_q;
        sram_en_d   = 1'b0;
        sram_we_d   = 1'b0;
        sram_addr_d = '0;
        load_a_d    = 1'b0;
        load_b_d    = 1'b0;
        row_valid_d = 1'b0;
        row_d       = '0;
        unit_go_d   = 3'b000;
        status_d    = status_q;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    op_d    = cmd_op;
                    src_b_d = cmd_src_b;
                    dst_d   = cmd_dst;
                    if (cmd_op == OP_BAD) begin
                        state_d  = S_DONE;
                        status_d = ST_BAD;
                    end else begin
                        state_d     = S_FETCH_A;
                        sram_en_d   = 1'b1;
                        sram_addr_d = cmd_src_a;
                    end
                end
            end
            S_FETCH_A: begin
                sram_en_d = 1'b1;
                load_a_d  = 1'b1;
                if (op_q == OP_ENC) begin
                    state_d     = S_STREAM;
                    r_d         = '0;
                    sram_addr_d = ADDR_WIDTH'(PK_BASE);
                end else begin
                    state_d     = S_FETCH_B;
                    sram_addr_d = (op_q == OP_DEC) ? ADDR_WIDTH'(SK_BASE) : src_b_q;
                end
            end
            S_FETCH_B: begin
                state_d  = S_DRAIN;
                load_b_d = 1'b1;
            end
            S_STREAM: begin
                // Each cycle presents the row whose read was issued the cycle before.
                row_valid_d = 1'b1;
                if (r_q == ROW_WIDTH'(BIG_N - 1)) begin
                    state_d = S_DRAIN;
                    row_d   = ROW_WIDTH'(BIG_N - 1);
                end else begin
                    r_d         = r_q + ROW_WIDTH'(1);
                    row_d       = r_q;
                    sram_en_d   = 1'b1;
                    sram_addr_d = ADDR_WIDTH'(PK_BASE) + ADDR_WIDTH'(r_d);
                end
            end
            S_DRAIN: begin
                state_d = S_WAIT;
                wcnt_d  = '0;
                case (op_q)
                    OP_ENC:  unit_go_d = 3'b001;
                    OP_DEC:  unit_go_d = 3'b010;
                    OP_ADD:  unit_go_d = 3'b100;
                    default: unit_go_d = 3'b000;
                endcase
            end
            S_WAIT: begin
                // unit_done in the go cycle is stale; done beats the timeout on the last cycle.
                if ((wcnt_q != '0) && unit_done) begin
                    state_d     = S_WRITE;
                    sram_en_d   = 1'b1;
                    sram_we_d   = 1'b1;
                    sram_addr_d = dst_q;
                end else if (wcnt_q == WAIT_W'(TIMEOUT - 1)) begin
                    state_d  = S_DONE;
                    status_d = ST_TMO;
                end else begin
                    wcnt_d = wcnt_q + WAIT_W'(1);
                end
            end
            S_WRITE: begin
                state_d  = S_DONE;
                status_d = ST_OK;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        cmd_ready_d = (state_d == S_IDLE);
        busy_d      = (state_d != S_IDLE);
        done_d      = (state_d == S_DONE);
    end

    // State, command latches and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            op_q        <= 2'b00;
            src_b_q     <= '0;
            dst_q       <= '0;
            r_q         <= '0;
            wcnt_q      <= '0;
            cmd_ready_q <= 1'b0;
            sram_en_q   <= 1'b0;
            sram_we_q   <= 1'b0;
            sram_addr_q <= '0;
            load_a_q    <= 1'b0;
            load_b_q    <= 1'b0;
            row_valid_q <= 1'b0;
            row_q       <= '0;
            unit_go_q   <= 3'b000;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            status_q    <= 2'b00;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            src_b_q     <= src_b_d;
            dst_q       <= dst_d;
            r_q         <= r_d;
            wcnt_q      <= wcnt_d;
            cmd_ready_q <= cmd_ready_d;
            sram_en_q   <= sram_en_d;
            sram_we_q   <= sram_we_d;
            sram_addr_q <= sram_addr_d;
            load_a_q    <= load_a_d;
            load_b_q    <= load_b_d;
            row_valid_q <= row_valid_d;
            row_q       <= row_d;
            unit_go_q   <= unit_go_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            status_q    <= status_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign sram_en   = sram_en_q;
    assign sram_we   = sram_we_q;
    assign sram_addr = sram_addr_q;
    assign load_a    = load_a_q;
    assign load_b    = load_b_q;
    assign row_valid = row_valid_q;
    assign row       = row_q;
    assign unit_go   = unit_go_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign status    = status_q;

endmodule

// File: tb/tb_lwe_op_controller.sv
// tb_lwe_op_controller: scoreboard bench for lwe_op_controller.
// The driver issues commands and pushes the expected per-cycle output beats.
// These beats come from a timeline model of each operation. A monitor pops
// and compares a beat on every cycle in which the DUT drives any activity output.
module tb_lwe_op_controller;

    localparam int N    = 4;
    localparam int RW   = 3;
    localparam int AW   = 8;
    localparam int PKB  = 254;
    localparam int SKB  = 32;
    localparam int TMO  = 8;

    localparam logic [1:0] ENC = 2'b00;
    localparam logic [1:0] DEC = 2'b01;
    localparam logic [1:0] ADD = 2'b10;
    localparam logic [1:0] BAD = 2'b11;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [1:0]    cmd_op = 2'b00;
    logic [AW-1:0] cmd_src_a = '0;
    logic [AW-1:0] cmd_src_b = '0;
    logic [AW-1:0] cmd_dst = '0;
    logic          sram_en;
    logic          sram_we;
    logic [AW-1:0] sram_addr;
    logic          load_a;
    logic          load_b;
    logic          row_valid;
    logic [RW-1:0] row;
    logic [2:0]    unit_go;
    logic          unit_done = 1'b0;
    logic          busy;
    logic          done;
    logic [1:0]    status;

    lwe_op_controller #(
        .BIG_N(N), .ROW_WIDTH(RW), .ADDR_WIDTH(AW),
        .PK_BASE(PKB), .SK_BASE(SKB), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_src_a(cmd_src_a), .cmd_src_b(cmd_src_b), .cmd_dst(cmd_dst),
        .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
        .load_a(load_a), .load_b(load_b), .row_valid(row_valid), .row(row),
        .unit_go(unit_go), .unit_done(unit_done),
        .busy(busy), .done(done), .status(status)
    );

    always #5 clk = ~clk;

    // One cycle's worth of observable activity; don't-care fields are zeroed.
    typedef struct packed {
        int            cyc;
        logic          en;
        logic          we;
        logic [AW-1:0] addr;
        logic          la;
        logic          lb;
        logic          rv;
        logic [RW-1:0] row;
        logic [2:0]    go;
        logic          dn;
        logic [1:0]    st;
        logic          busy;
        logic          rdy;
    } beat_t;

    beat_t exp_q[$];
    beat_t obs_b;
    beat_t exp_b;
    int    cyc = 0;
    int    checks = 0;
    int    failures = 0;
    int    prev_done = -1;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic beat_t mk(input int c);
        beat_t e;
        e      = '0;
        e.cyc  = c;
        e.busy = 1'b1;
        return e;
    endfunction

    // Expected timeline of one command accepted in cycle t; k = WAIT index of unit_done, 0 = none.
    task automatic push_model(input logic [1:0] op, input logic [AW-1:0] a, input logic [AW-1:0] b,
                              input logic [AW-1:0] dst, input int k, input int t);
        beat_t e;
        int    w;
        logic [2:0] go;
        if (op == BAD) begin
            e = mk(t + 1); e.dn = 1'b1; e.st = 2'b01; exp_q.push_back(e);
            return;
        end
        e = mk(t + 1); e.en = 1'b1; e.addr = a; exp_q.push_back(e);
        if (op == ENC) begin
            for (int i = 0; i < N; i++) begin
                e = mk(t + 2 + i); e.en = 1'b1; e.addr = AW'(PKB + i);
                e.la = (i == 0); e.rv = (i > 0);
                if (i > 0) e.row = RW'(i - 1);
                exp_q.push_back(e);
            end
            e = mk(t + 2 + N); e.rv = 1'b1; e.row = RW'(N - 1); exp_q.push_back(e);
            w  = t + 3 + N;
            go = 3'b001;
        end else begin
            e = mk(t + 2); e.en = 1'b1; e.la = 1'b1;
            e.addr = (op == DEC) ? AW'(SKB) : b;
            exp_q.push_back(e);
            e = mk(t + 3); e.lb = 1'b1; exp_q.push_back(e);
            w  = t + 4;
            go = (op == DEC) ? 3'b010 : 3'b100;
        end
        e = mk(w); e.go = go; exp_q.push_back(e);
        if (k > 0) begin
            e = mk(w + k + 1); e.en = 1'b1; e.we = 1'b1; e.addr = dst; exp_q.push_back(e);
            e = mk(w + k + 2); e.dn = 1'b1; e.st = 2'b00; exp_q.push_back(e);
        end else begin
            e = mk(w + TMO); e.dn = 1'b1; e.st = 2'b10; exp_q.push_back(e);
        end
    endtask

    // Monitor: any activity output high means the DUT presented a beat.
    always @(negedge clk) begin
        if (sram_en || sram_we || load_a || load_b || row_valid || (unit_go != 3'b000) || done) begin
            obs_b      = '0;
            obs_b.cyc  = cyc;
            obs_b.en   = sram_en;
            obs_b.we   = sram_we;
            obs_b.addr = (sram_en || sram_we) ? sram_addr : '0;
            obs_b.la   = load_a;
            obs_b.lb   = load_b;
            obs_b.rv   = row_valid;
            obs_b.row  = row_valid ? row : '0;
            obs_b.go   = unit_go;
            obs_b.dn   = done;
            obs_b.st   = done ? status : 2'b00;
            obs_b.busy = busy;
            obs_b.rdy  = cmd_ready;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_beat cyc=%0d en=%b we=%b addr=%h la=%b lb=%b rv=%b row=%0d go=%b dn=%b st=%b",
                         cyc, sram_en, sram_we, sram_addr, load_a, load_b, row_valid, row, unit_go, done, status);
            end else begin
                exp_b = exp_q.pop_front();
                if (obs_b !== exp_b) begin
                    failures++;
                    $display("FAIL beat got cyc=%0d en=%b we=%b addr=%h la=%b lb=%b rv=%b row=%0d go=%b dn=%b st=%b busy=%b rdy=%b | exp cyc=%0d en=%b we=%b addr=%h la=%b lb=%b rv=%b row=%0d go=%b dn=%b st=%b busy=%b rdy=%b",
                             obs_b.cyc, obs_b.en, obs_b.we, obs_b.addr, obs_b.la, obs_b.lb, obs_b.rv, obs_b.row,
                             obs_b.go, obs_b.dn, obs_b.st, obs_b.busy, obs_b.rdy,
                             exp_b.cyc, exp_b.en, exp_b.we, exp_b.addr, exp_b.la, exp_b.lb, exp_b.rv, exp_b.row,
                             exp_b.go, exp_b.dn, exp_b.st, exp_b.busy, exp_b.rdy);
                end
            end
        end
    end

    task automatic check_all_zero(input string name);
        logic [31:0] v;
        v = 32'({cmd_ready, sram_en, sram_we, sram_addr, load_a, load_b, row_valid, row,
                 unit_go, busy, done, status});
        checks++;
        if (v != 32'd0) begin
            failures++;
            $display("FAIL %s outputs=%h required=0", name, v);
        end
    endtask

    // Issue one command (cmd_valid stays high) and drive unit_done for its whole timeline.
    // abort_off > 0 asserts reset in that cycle instead of letting the command finish.
    task automatic run_cmd(input logic [1:0] op, input logic [AW-1:0] a, input logic [AW-1:0] b,
                           input logic [AW-1:0] dst, input int k, input bit noise, input int abort_off);
        int  t;
        int  w;
        int  last;
        int  wait_end;
        bit  found;
        cmd_op    = op;
        cmd_src_a = a;
        cmd_src_b = b;
        cmd_dst   = dst;
        cmd_valid = 1'b1;
        unit_done = noise ? 1'($urandom % 2) : 1'b0;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (cmd_ready === 1'b1) found = 1'b1;
            else begin
                @(negedge clk);
                unit_done = noise ? 1'($urandom % 2) : 1'b0;
            end
        end
        if (!found) begin
            checks++; failures++;
            $display("FAIL accept_timeout cyc=%0d cmd_ready=%b required=1", cyc, cmd_ready);
            return;
        end
        t = cyc;
        if (prev_done >= 0) begin
            checks++;
            if (t != prev_done + 1) begin
                failures++;
                $display("FAIL ready_cycle got=%0d required=%0d", t, prev_done + 1);
            end
        end
        push_model(op, a, b, dst, k, t);
        w        = (op == ENC) ? 3 + N : 4;
        wait_end = (k > 0) ? w + k : w + TMO - 1;
        if (op == BAD)  last = 1;
        else if (k > 0) last = w + k + 2;
        else            last = w + TMO;
        for (int o = 1; o <= last; o++) begin
            @(negedge clk);
            if (o == abort_off) begin
                #1 rst_n = 1'b0;
                unit_done = 1'b0;
                #1 check_all_zero("reset_abort");
                exp_q.delete();
                repeat (2) @(negedge clk);
                #1 rst_n = 1'b1;
                prev_done = cyc;
                return;
            end
            if (op != BAD && o > w && o <= wait_end)
                unit_done = (k > 0) && (o == w + k);
            else
                unit_done = noise ? 1'($urandom % 2) : 1'b0;
        end
        prev_done = t + last;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] rop;
        int         rk;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset_state");
        #1 rst_n = 1'b1;
        prev_done = cyc;

        run_cmd(ADD, 8'h40, 8'h41, 8'h50, 2, 1'b0, 0);
        run_cmd(ENC, 8'h10, 8'h00, 8'h60, 3, 1'b1, 0);
        run_cmd(DEC, 8'h22, 8'h00, 8'h70, 0, 1'b1, 0);
        run_cmd(BAD, 8'h33, 8'h34, 8'h35, 0, 1'b1, 0);
        run_cmd(DEC, 8'h80, 8'h00, 8'h81, 1, 1'b1, 0);
        run_cmd(ADD, 8'hF0, 8'hF1, 8'hFF, TMO - 1, 1'b1, 0);
        run_cmd(ENC, 8'h11, 8'h00, 8'h12, 2, 1'b1, 3);
        run_cmd(ADD, 8'h01, 8'h02, 8'h03, 1, 1'b1, 0);
        run_cmd(ADD, 8'h04, 8'h05, 8'h06, 2, 1'b1, 7);
        run_cmd(ADD, 8'h40, 8'h41, 8'h50, 2, 1'b0, 0);

        for (int n = 0; n < 30; n++) begin
            rop = 2'($urandom % 4);
            rk  = (($urandom % 5) == 0) ? 0 : 1 + int'($urandom % (TMO - 1));
            run_cmd(rop, 8'($urandom), 8'($urandom), 8'($urandom), rk, 1'b1, 0);
        end

        cmd_valid = 1'b0;
        unit_done = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL leftover_beats got=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
